// File: rtl/lab5_pkg.sv
// Shared definitions for the coin credit bank.
// Holds the default coin price and game-count ceiling, the coin type
// encoding seen on the CoinValue pins, and the states of the coin slot FSM.
package lab5_pkg;

   localparam int COIN_PRICE = 4;
   localparam int MAX_GAMES  = 7;

   typedef enum logic [1:0] {
      COIN_NONE  = 2'b00,
      COIN_ONE   = 2'b01,
      COIN_TWO   = 2'b10,
      COIN_THREE = 2'b11
   } coin_t;

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } coinState_t;

   // The coin encoding is its own unit value, widened to the accumulator width.
   function automatic logic [3:0] coinUnits(input coin_t coin);
      return {2'b00, coin};
   endfunction

endpackage

// File: rtl/coin_pulse.sv
// Coin slot event detector.
// Turns the level-type CoinInserted signal from the coin slot into a single
// coin event per insertion, and presents the coin type sampled on that edge.
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-low
//   CoinInserted - slot level, one coin per 0->1 transition
//   CoinValue    - coin type, only meaningful on the event edge
//   coinEvent    - high for the one cycle in which a new coin is seen
//   coinValue    - CoinValue captured with the event, 00 otherwise
module coin_pulse (
   input  logic       clock,
   input  logic       reset,
   input  logic       CoinInserted,
   input  logic [1:0] CoinValue,
   output logic       coinEvent,
   output logic [1:0] coinValue
);

   import lab5_pkg::*;

   coinState_t state;
   coinState_t stateNext;
   logic       prevInserted;

   // prevInserted comes out of reset as 1 so that a slot which is already
   // held high when reset is released is not mistaken for a fresh coin.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state        <= IDLE;
         prevInserted <= 1'b1;
      end else begin
         state        <= stateNext;
         prevInserted <= CoinInserted;
      end
   end

   // A coin is only recognised from IDLE, so however long the slot stays
   // high in HELD no second coin is produced; the slot must fall first.
   always_comb begin
      stateNext = state;
      coinEvent = 1'b0;
      coinValue = 2'b00;
      case (state)
         IDLE: begin
            if (CoinInserted && !prevInserted) begin
               coinEvent = 1'b1;
               coinValue = CoinValue;
               stateNext = HELD;
            end
         end
         HELD: begin
            if (!CoinInserted) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: rtl/coin_credit_bank.sv
// Coin credit bank for an arcade-style game controller.
// Accumulates coin units into partial credit, converts every PRICE units
// into one paid game, and hands games out on GameStarted pulses.
// Ports:
//   clock        - system clock, rising edge
//   reset        - synchronous, active-low
//   CoinValue    - coin type (00 invalid, 01/10/11 = 1/2/3 units)
//   CoinInserted - coin slot level
//   GameStarted  - one-cycle pulse, consumes one paid game
//   NumGames     - paid games not yet started, saturates at MAX_GAMES
//   Credit       - units collected toward the next game
//   CoinAccepted - one-cycle pulse when a coin was counted
//   Drop         - one-cycle pulse when a coin was returned
//   CanStart     - high whenever NumGames is non-zero
module coin_credit_bank #(
   parameter int PRICE     = lab5_pkg::COIN_PRICE,
   parameter int MAX_GAMES = lab5_pkg::MAX_GAMES
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] CoinValue,
   input  logic       CoinInserted,
   input  logic       GameStarted,
   output logic [3:0] NumGames,
   output logic [2:0] Credit,
   output logic       CoinAccepted,
   output logic       Drop,
   output logic       CanStart
);

   import lab5_pkg::*;

   localparam logic [3:0] PRICE_U = 4'(PRICE);
   localparam logic [3:0] MAX_U   = 4'(MAX_GAMES);

   logic       coinEvent;
   logic [1:0] coinValue;
   logic [3:0] sum;
   logic       reject;
   logic       accept;
   logic       award;
   logic       consume;
   logic [3:0] gamesNext;
   logic [2:0] creditNext;

   coin_pulse uPulse (
      .clock        (clock),
      .reset        (reset),
      .CoinInserted (CoinInserted),
      .CoinValue    (CoinValue),
      .coinEvent    (coinEvent),
      .coinValue    (coinValue)
   );

   // The saturation test looks at the registered NumGames, so a game being
   // started on the same edge does not make room for this coin. An award and
   // a consume on the same edge cancel out and leave NumGames as it was.
   always_comb begin
      sum        = {1'b0, Credit} + coinUnits(coin_t'(coinValue));
      reject     = coinEvent && ((coinValue == 2'b00) || (NumGames == MAX_U));
      accept     = coinEvent && !reject;
      award      = accept && (sum >= PRICE_U);
      consume    = GameStarted && (NumGames != 4'd0);
      creditNext = Credit;
      if (accept) begin
         creditNext = award ? 3'(sum - PRICE_U) : sum[2:0];
      end
      gamesNext = NumGames;
      if (award && !consume) begin
         gamesNext = NumGames + 4'd1;
      end else if (consume && !award) begin
         gamesNext = NumGames - 4'd1;
      end
   end

   // CanStart is derived from the next count so that it always agrees with
   // the NumGames value registered on the same edge.
   always_ff @(posedge clock) begin
      if (!reset) begin
         NumGames     <= 4'd0;
         Credit       <= 3'd0;
         CoinAccepted <= 1'b0;
         Drop         <= 1'b0;
         CanStart     <= 1'b0;
      end else begin
         NumGames     <= gamesNext;
         Credit       <= creditNext;
         CoinAccepted <= accept;
         Drop         <= reject;
         CanStart     <= (gamesNext != 4'd0);
      end
   end

endmodule

// File: tb/tb_coin_credit_bank.sv
// Self-checking bench for coin_credit_bank.
// Stimulus drives one clock cycle at a time and pushes the expected outputs
// for that edge, computed by a simple coin/credit model, into a queue. An
// independent monitor pops one expectation per cycle and compares.
module tb_coin_credit_bank;

   localparam int PRICE = 4;
   localparam int MAXG  = 7;

   typedef struct {
      int games;
      int credit;
      bit accepted;
      bit drop;
      bit canStart;
   } expect_t;

   logic       clock;
   logic       reset;
   logic [1:0] CoinValue;
   logic       CoinInserted;
   logic       GameStarted;
   logic [3:0] NumGames;
   logic [2:0] Credit;
   logic       CoinAccepted;
   logic       Drop;
   logic       CanStart;

   expect_t expQ[$];
   int      checks = 0;
   int      errors = 0;

   int mGames  = 0;
   int mCredit = 0;
   bit mLast   = 1'b1;

   coin_credit_bank #(.PRICE(PRICE), .MAX_GAMES(MAXG)) dut (
      .clock        (clock),
      .reset        (reset),
      .CoinValue    (CoinValue),
      .CoinInserted (CoinInserted),
      .GameStarted  (GameStarted),
      .NumGames     (NumGames),
      .Credit       (Credit),
      .CoinAccepted (CoinAccepted),
      .Drop         (Drop),
      .CanStart     (CanStart)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs, work out what the bank should show after the
   // coming edge, queue it, and advance past that edge.
   task automatic applyStimulus(input bit rstN, input bit slot,
                                input logic [1:0] value, input bit start);
      expect_t e;
      bit      ev;
      int      total;
      reset        = rstN;
      CoinInserted = slot;
      CoinValue    = value;
      GameStarted  = start;
      e.accepted = 1'b0;
      e.drop     = 1'b0;
      if (!rstN) begin
         mGames  = 0;
         mCredit = 0;
         mLast   = 1'b1;
      end else begin
         ev    = slot && !mLast;
         mLast = slot;
         total = mCredit;
         if (ev) begin
            if (value == 2'b00 || mGames == MAXG) begin
               e.drop = 1'b1;
            end else begin
               e.accepted = 1'b1;
               total = mCredit + int'(value);
            end
         end
         if (start && mGames > 0) mGames = mGames - 1;
         if (e.accepted) begin
            if (total >= PRICE) begin
               mGames  = mGames + 1;
               mCredit = total - PRICE;
            end else begin
               mCredit = total;
            end
         end
      end
      e.games    = mGames;
      e.credit   = mCredit;
      e.canStart = (mGames != 0);
      expQ.push_back(e);
      @(posedge clock);
      #1;
   endtask

   // Insert a coin: slot high for some cycles, then low; CoinValue is
   // scrambled on the non-event edges since it must be ignored there.
   task automatic coin(input logic [1:0] value, input int high, input int low);
      applyStimulus(1'b1, 1'b1, value, 1'b0);
      for (int i = 1; i < high; i++) applyStimulus(1'b1, 1'b1, 2'($urandom), 1'b0);
      for (int i = 0; i < low; i++) applyStimulus(1'b1, 1'b0, 2'($urandom), 1'b0);
   endtask

   task automatic doReset(input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic checkOutput(input expect_t e);
      checks++;
      if (NumGames !== 4'(e.games)) begin
         errors++;
         $display("[TB] FAIL NumGames at %0t: got %0d, expected %0d", $time, NumGames, e.games);
      end
      checks++;
      if (Credit !== 3'(e.credit)) begin
         errors++;
         $display("[TB] FAIL Credit at %0t: got %0d, expected %0d", $time, Credit, e.credit);
      end
      checks++;
      if (CoinAccepted !== e.accepted) begin
         errors++;
         $display("[TB] FAIL CoinAccepted at %0t: got %b, expected %b", $time, CoinAccepted, e.accepted);
      end
      checks++;
      if (Drop !== e.drop) begin
         errors++;
         $display("[TB] FAIL Drop at %0t: got %b, expected %b", $time, Drop, e.drop);
      end
      checks++;
      if (CanStart !== e.canStart) begin
         errors++;
         $display("[TB] FAIL CanStart at %0t: got %b, expected %b", $time, CanStart, e.canStart);
      end
   endtask

   // Monitor: registered outputs settle after each rising edge, so compare
   // on the falling edge against the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clock);
         if (expQ.size() != 0) checkOutput(expQ.pop_front());
      end
   end

   initial begin
      bit slotLevel;
      int guard;
      reset        = 1'b0;
      CoinInserted = 1'b0;
      CoinValue    = 2'b00;
      GameStarted  = 1'b0;

      // Five two-unit coins: credit 2,0,2,0,2 and games 0,1,1,2,2.
      doReset(2);
      for (int i = 0; i < 5; i++) coin(2'b10, 1, 1);

      // A three-unit coin held in the slot for six cycles counts once.
      doReset(2);
      coin(2'b11, 6, 2);

      // Fill up to the game ceiling, then one more coin is returned, also
      // when a game starts on that same edge.
      doReset(2);
      guard = 0;
      while (mGames < MAXG && guard < 40) begin
         coin(2'b11, 1, 1);
         guard++;
      end
      coin(2'b11, 2, 1);
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);

      // One game and three units of credit; a one-unit coin arriving with
      // GameStarted leaves one game and clears the credit.
      doReset(2);
      coin(2'b11, 1, 1);
      coin(2'b11, 1, 1);
      coin(2'b01, 1, 1);
      applyStimulus(1'b1, 1'b1, 2'b01, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);

      // Start with no games is ignored; an invalid coin is dropped.
      doReset(2);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b1);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
      coin(2'b01, 1, 1);
      coin(2'b00, 1, 1);

      // Reset in the middle of a held coin with three games banked; the
      // slot is still high after release and must not count.
      doReset(2);
      for (int i = 0; i < 4; i++) coin(2'b11, 1, 1);
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
      applyStimulus(1'b1, 1'b1, 2'b10, 1'b0);
      applyStimulus(1'b0, 1'b1, 2'b10, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 2'b11, 1'b0);
      applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
      coin(2'b10, 1, 1);

      // Random traffic, with occasional resets.
      slotLevel = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 4) slotLevel = !slotLevel;
         applyStimulus($urandom_range(0, 79) != 0, slotLevel,
                       2'($urandom), $urandom_range(0, 3) == 0);
      end

      guard = 0;
      while (expQ.size() != 0 && guard < 5) begin
         @(posedge clock);
         guard++;
      end
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coin_credit_bank.md
COIN_CREDIT_BANK -- requirements
Module: coin_credit_bank

Interface
REQ-001 Parameter PRICE, default 4: coin units per game credit; legal range 2..7.
REQ-002 Parameter MAX_GAMES, default 7: saturation limit of NumGames; legal range 1..15.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-low; asserted when 0 at a rising clock edge.
REQ-005 CoinValue  input  2  coin type: 00 invalid, 01 = 1 unit, 10 = 2 units, 11 = 3 units.
REQ-006 CoinInserted  input  1  level from coin slot; one coin per 0->1 transition.
REQ-007 GameStarted  input  1  one-cycle pulse from game FSM; consumes one credit.
REQ-008 NumGames  output  4  registered count of paid, unstarted games.
REQ-009 Credit  output  3  registered partial units toward next game, always < PRICE.
REQ-010 CoinAccepted  output  1  registered one-cycle pulse: coin counted.
REQ-011 Drop  output  1  registered one-cycle pulse: coin returned (rejected).
REQ-012 CanStart  output  1  registered; 1 iff NumGames != 0.

Function
REQ-013 SHALL register CoinInserted as prevInserted; a coin event is CoinInserted=1 and prevInserted=0 at a clock edge.
REQ-014 SHALL sample CoinValue on the same edge as the coin event; CoinValue is ignored at all other edges.
REQ-015 SHALL hold the coin FSM in IDLE until a coin event, then go to HELD; HELD -> IDLE when CoinInserted=0.
REQ-016 SHALL never count a second coin while in HELD, however long CoinInserted stays high.
REQ-017 On a coin event with CoinValue=00, SHALL pulse Drop and leave Credit and NumGames unchanged.
REQ-018 On a coin event with NumGames=MAX_GAMES, SHALL pulse Drop and leave Credit unchanged.
REQ-019 Otherwise, SHALL compute sum = Credit + value at 4-bit width.
REQ-020 If sum >= PRICE, SHALL increment NumGames and load Credit with sum - PRICE; else SHALL load Credit with sum. Either way, SHALL pulse CoinAccepted.
REQ-021 Outputs SHALL reflect the coin on the edge where the coin event is detected: 1-cycle latency from input sample to registered output.
REQ-022 On a GameStarted pulse with NumGames>0, SHALL decrement NumGames. On a GameStarted pulse with NumGames=0, SHALL ignore the pulse with no underflow.
REQ-023 If an award and a consume occur on the same edge, SHALL leave NumGames unchanged, with Credit updated per REQ-020.
REQ-024 The saturation check in REQ-018 SHALL use the pre-edge NumGames, even if a consume happens on the same edge.
REQ-025 CoinAccepted and Drop SHALL never both be 1, and each SHALL be high for exactly one cycle per coin event.
REQ-026 CanStart SHALL equal the registered NumGames != 0 at all times after reset.

Reset
REQ-027 On reset=0 at an edge, SHALL set NumGames=0, Credit=0, CoinAccepted=0, Drop=0, CanStart=0, and FSM=IDLE.
REQ-028 Reset SHALL set prevInserted=1, so a slot already held high at reset release produces no coin event.
REQ-029 Reset SHALL override all other inputs on the same edge, including mid-HELD and a simultaneous GameStarted.

Structure
REQ-030 lab5_pkg SHALL hold: COIN_PRICE=4, MAX_GAMES=7, coin_t enum (COIN_NONE, COIN_ONE, COIN_TWO, COIN_THREE), and coinState_t enum (IDLE, HELD).
REQ-031 The coin event detection (REQ-013..016) SHALL live in one sub-module, coin_pulse, which outputs a one-cycle event and the sampled value.
REQ-032 The accumulator, saturation logic and consume logic SHALL live in the coin_credit_bank top level.

Verification
REQ-033 Reset, then five CoinValue=10 coins, each 1 cycle high and 1 low -> Credit sequence 2, 0, 2, 0, 2; NumGames 0, 1, 1, 2, 2; five CoinAccepted pulses.
REQ-034 CoinValue=11 with CoinInserted held high 6 cycles -> exactly one CoinAccepted; Credit=3; NumGames=0.
REQ-035 Coins of 3 units until NumGames=7, then one more 3-unit coin -> Drop pulses; Credit and NumGames=7 unchanged.
REQ-036 NumGames=1, Credit=3; a CoinValue=01 coin event on the same edge as GameStarted -> NumGames=1, Credit=0, CoinAccepted=1.
REQ-037 GameStarted with NumGames=0 -> NumGames stays 0 and CanStart stays 0; a CoinValue=00 coin -> Drop=1, Credit unchanged.
REQ-038 reset=0 while HELD with NumGames=3 -> all outputs zero next cycle; slot still high after release -> no coin counted.
